// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: scans a double-buffered hex value onto an N-digit
// common-anode 7-segment display, advancing one digit per s_clk edge.
//
// Ports:
//   clk       system clock; all logic runs here
//   reset     synchronous, active-low reset
//   s_clk     divided scan clock, sampled as data; each edge is a tick
//   data_in   hex value, nibble i drives digit i (digit 0 = LS nibble)
//   load      1-cycle strobe, captures data_in into staging
//   load_ack  1-cycle pulse when staging is committed to the display
//   an        one-hot digit select, polarity per ANODE_ACTIVE_LOW
//   seg       {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//   dp        decimal point, held inactive
module seg7_scan_mux #(
    parameter int N_DIGITS         = 4,
    parameter bit ANODE_ACTIVE_LOW = 1'b1,
    parameter bit SEG_ACTIVE_LOW   = 1'b1,
    parameter bit BLANK_LEADING    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_clk,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic                  load,
    output logic                  load_ack,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [IDX_W-1:0]    LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);
    localparam logic [N_DIGITS-1:0] AN_OFF = {N_DIGITS{ANODE_ACTIVE_LOW}};
    localparam logic [6:0]          SEG_OFF = {7{SEG_ACTIVE_LOW}};

    logic                  s_q;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] staging;
    logic [4*N_DIGITS-1:0] disp;
    logic                  pend;

    logic                  tick;
    logic                  wrap;
    logic                  blank;
    logic [4*N_DIGITS-1:0] upper;
    logic [3:0]            nib;
    logic [N_DIGITS-1:0]   an_sel;
    logic [6:0]            seg_lit;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [6:0]            seg_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] p;
        case (h)
            4'h0:    p = 7'b0111111;
            4'h1:    p = 7'b0000110;
            4'h2:    p = 7'b1011011;
            4'h3:    p = 7'b1001111;
            4'h4:    p = 7'b1100110;
            4'h5:    p = 7'b1101101;
            4'h6:    p = 7'b1111101;
            4'h7:    p = 7'b0000111;
            4'h8:    p = 7'b1111111;
            4'h9:    p = 7'b1101111;
            4'hA:    p = 7'b1110111;
            4'hB:    p = 7'b1111100;
            4'hC:    p = 7'b0111001;
            4'hD:    p = 7'b1011110;
            4'hE:    p = 7'b1111001;
            default: p = 7'b1110001;
        endcase
        return p;
    endfunction

    // Each s_clk edge, rising or falling, yields exactly one tick.
    assign tick = s_clk ^ s_q;
    assign wrap = tick && (idx == LAST);

    // Nibbles from the current digit upward; all-zero means this digit
    // is a leading zero.
    assign upper = disp >> {idx, 2'b00};
    assign nib   = disp[{idx, 2'b00} +: 4];
    assign blank = BLANK_LEADING && (idx != '0) && (upper == '0);

    always_comb begin
        an_sel  = blank ? '0 : (AN_ONE << idx);
        seg_lit = blank ? '0 : hex7(nib);
    end

    // XOR with the "off" pattern applies the output polarity.
    assign an_nxt  = an_sel ^ AN_OFF;
    assign seg_nxt = seg_lit ^ SEG_OFF;
    assign dp      = SEG_ACTIVE_LOW;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s_q      <= 1'b0;
            idx      <= '0;
            staging  <= '0;
            disp     <= '0;
            pend     <= 1'b0;
            load_ack <= 1'b0;
            an       <= AN_OFF;
            seg      <= SEG_OFF;
        end else begin
            s_q <= s_clk;
            if (tick) begin
                idx <= wrap ? '0 : idx + 1'b1;
            end
            load_ack <= wrap && pend;
            if (wrap && pend) begin
                disp <= staging;
                pend <= 1'b0;
            end
            // A load in the commit cycle lands in staging after the old
            // staging has moved to disp, and keeps a commit pending.
            if (load) begin
                staging <= data_in;
                pend    <= 1'b1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: scoreboard bench for seg7_scan_mux (4 digits,
// active-low anodes and segments, leading-zero blanking).
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_clk = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = 16'h0;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    seg7_scan_mux dut (
        .clk      (clk),
        .reset    (reset),
        .s_clk    (s_clk),
        .data_in  (data_in),
        .load     (load),
        .load_ack (load_ack),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       ack;
    } obs_t;

    obs_t        exp_q[$];
    logic [6:0]  seg_tbl [16];
    logic [3:0]  an_std [4];
    int          m_idx;
    logic [15:0] m_disp;
    logic [15:0] m_stg;
    logic        m_pend;
    logic        m_sq;
    logic        s_cur = 1'b0;
    int          checks = 0;
    int          passed = 0;

    // Drive one cycle, push the model's expected outputs for the next
    // edge, then sample after that edge and pop the expectation.
    task automatic step(input logic rst, input logic tog, input logic ld,
                        input logic [15:0] d,
                        output obs_t o, output obs_t e);
        obs_t x;
        logic tk;
        logic wr;
        @(negedge clk);
        if (tog) s_cur = ~s_cur;
        reset   = rst;
        s_clk   = s_cur;
        load    = ld;
        data_in = d;
        x.an  = 4'b1111;
        x.seg = 7'h7F;
        x.ack = 1'b0;
        if (!rst) begin
            m_sq   = 1'b0;
            m_idx  = 0;
            m_disp = 16'h0;
            m_stg  = 16'h0;
            m_pend = 1'b0;
        end else begin
            if (m_idx == 0 || (m_disp >> (4 * m_idx)) != 16'h0) begin
                x.an[m_idx] = 1'b0;
                x.seg = ~seg_tbl[m_disp[4*m_idx +: 4]];
            end
            tk = s_cur ^ m_sq;
            wr = tk && (m_idx == 3);
            x.ack = wr && m_pend;
            if (wr && m_pend) begin
                m_disp = m_stg;
                m_pend = 1'b0;
            end
            if (ld) begin
                m_stg  = d;
                m_pend = 1'b1;
            end
            if (tk) m_idx = wr ? 0 : m_idx + 1;
            m_sq = s_cur;
        end
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        o = '{an, seg, load_ack};
        e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        obs_t o, e;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, (i != 0), 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL reset_q[%0d] got %b want %b", i, o, e);
            else passed++;
            checks++;
            if ({an, seg, load_ack, dp} !== 13'b1111_1111111_0_1)
                $display("FAIL reset_val[%0d] got %b want 1111111111101",
                         i, {an, seg, load_ack, dp});
            else passed++;
        end
        step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
        checks++;
        if (o !== e) $display("FAIL release_q got %b want %b", o, e);
        else passed++;
        checks++;
        if ({o.an, o.seg, o.ack} !== 12'b1110_1000000_0)
            $display("FAIL release_dig0 got %b want 111010000000", o);
        else passed++;
    endtask

    task automatic test_load();
        obs_t o, e;
        int acks;
        logic [6:0] seg_x [4];
        seg_x = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
        acks = 0;
        step(1'b1, 1'b0, 1'b1, 16'h1234, o, e);
        checks++;
        if (o !== e) $display("FAIL load_q got %b want %b", o, e);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL load_scan_q[%0d] got %b want %b", i, o, e);
            else passed++;
            if (o.ack) acks++;
            if (i == 0) begin
                checks++;
                if (o.seg !== 7'b1000000)
                    $display("FAIL load_old_disp got %b want 1000000", o.seg);
                else passed++;
            end
        end
        checks++;
        if (acks != 1 || !o.ack)
            $display("FAIL load_ack count=%0d last=%b want 1 last=1", acks, o.ack);
        else passed++;
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL load_hold_q[%0d] got %b want %b", d, o, e);
            else passed++;
            checks++;
            if ({o.an, o.seg} !== {an_std[d], seg_x[d]})
                $display("FAIL load_dig[%0d] got %b want %b",
                         d, {o.an, o.seg}, {an_std[d], seg_x[d]});
            else passed++;
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL load_adv_q[%0d] got %b want %b", d, o, e);
            else passed++;
        end
    endtask

    task automatic test_blank();
        obs_t o, e;
        int acks;
        logic [3:0] an_x [4];
        logic [6:0] seg_x [4];
        an_x  = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        seg_x = '{7'b0010010, 7'h7F, 7'h7F, 7'h7F};
        acks = 0;
        step(1'b1, 1'b0, 1'b1, 16'h0005, o, e);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL blank_scan_q[%0d] got %b want %b", i, o, e);
            else passed++;
            if (o.ack) acks++;
        end
        checks++;
        if (acks != 1) $display("FAIL blank_ack count=%0d want 1", acks);
        else passed++;
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL blank_hold_q[%0d] got %b want %b", d, o, e);
            else passed++;
            checks++;
            if ({o.an, o.seg} !== {an_x[d], seg_x[d]})
                $display("FAIL blank_dig[%0d] got %b want %b",
                         d, {o.an, o.seg}, {an_x[d], seg_x[d]});
            else passed++;
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
        end
    endtask

    task automatic test_double_load();
        obs_t o, e;
        int acks;
        logic [6:0] seg_x [4];
        seg_x = '{7'b0001110, 7'b0000110, 7'b0000110, 7'b0000011};
        acks = 0;
        step(1'b1, 1'b0, 1'b1, 16'hAAAA, o, e);
        step(1'b1, 1'b1, 1'b1, 16'hBEEF, o, e);
        checks++;
        if (o !== e) $display("FAIL dbl_q got %b want %b", o, e);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL dbl_scan_q[%0d] got %b want %b", i, o, e);
            else passed++;
            if (o.ack) acks++;
        end
        checks++;
        if (acks != 1) $display("FAIL dbl_ack count=%0d want 1", acks);
        else passed++;
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
            checks++;
            if ({o.an, o.seg} !== {an_std[d], seg_x[d]})
                $display("FAIL dbl_dig[%0d] got %b want %b",
                         d, {o.an, o.seg}, {an_std[d], seg_x[d]});
            else passed++;
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL dbl_adv_q[%0d] got %b want %b", d, o, e);
            else passed++;
        end
    endtask

    task automatic test_wrap_load();
        obs_t o, e;
        int acks;
        logic [6:0] seg_x [4];
        seg_x = '{7'b0000110, 7'b0100001, 7'b1000000, 7'b1000110};
        step(1'b1, 1'b0, 1'b1, 16'h1111, o, e);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
        step(1'b1, 1'b1, 1'b1, 16'hC0DE, o, e);
        checks++;
        if (o !== e) $display("FAIL wrapld_q got %b want %b", o, e);
        else passed++;
        checks++;
        if (o.ack !== 1'b1) $display("FAIL wrapld_ack1 got %b want 1", o.ack);
        else passed++;
        step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
        checks++;
        if ({o.an, o.seg, o.ack} !== 12'b1110_1111001_0)
            $display("FAIL wrapld_old got %b want 111011110010", o);
        else passed++;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL wrapld_scan_q[%0d] got %b want %b", i, o, e);
            else passed++;
            if (o.ack) acks++;
        end
        checks++;
        if (acks != 1 || !o.ack)
            $display("FAIL wrapld_ack2 count=%0d last=%b want 1 last=1", acks, o.ack);
        else passed++;
        for (int d = 0; d < 4; d++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
            checks++;
            if ({o.an, o.seg} !== {an_std[d], seg_x[d]})
                $display("FAIL wrapld_dig[%0d] got %b want %b",
                         d, {o.an, o.seg}, {an_std[d], seg_x[d]});
            else passed++;
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
        end
    endtask

    task automatic test_decode();
        obs_t o, e;
        logic [15:0] vals [2];
        vals = '{16'h6789, 16'hA000};
        for (int v = 0; v < 2; v++) begin
            step(1'b1, 1'b0, 1'b1, vals[v], o, e);
            for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            for (int d = 0; d < 4; d++) begin
                step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
                checks++;
                if (o !== e)
                    $display("FAIL decode_q[%0d][%0d] got %b want %b", v, d, o, e);
                else passed++;
                step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o, e;
        int acks;
        step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
        step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
        step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
        checks++;
        if (o !== e) $display("FAIL b2b_q got %b want %b", o, e);
        else passed++;
        checks++;
        if ({o.an, o.seg} !== 11'b1011_1000000)
            $display("FAIL b2b_dig2 got %b want 10111000000", {o.an, o.seg});
        else passed++;
        step(1'b1, 1'b0, 1'b1, 16'h4321, o, e);
        step(1'b0, 1'b0, 1'b0, 16'h0, o, e);
        checks++;
        if ({o.an, o.seg, o.ack} !== 12'b1111_1111111_0)
            $display("FAIL midreset got %b want 111111111110", o);
        else passed++;
        step(1'b1, 1'b0, 1'b0, 16'h0, o, e);
        checks++;
        if ({o.an, o.seg} !== 11'b1110_1000000)
            $display("FAIL midreset_dig0 got %b want 11101000000", {o.an, o.seg});
        else passed++;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 16'h0, o, e);
            checks++;
            if (o !== e) $display("FAIL midreset_q[%0d] got %b want %b", i, o, e);
            else passed++;
            if (o.ack) acks++;
        end
        checks++;
        if (acks != 0) $display("FAIL midreset_ack count=%0d want 0", acks);
        else passed++;
    endtask

    initial begin
        seg_tbl = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        an_std  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        m_idx  = 0;
        m_disp = 16'h0;
        m_stg  = 16'h0;
        m_pend = 1'b0;
        m_sq   = 1'b0;
        test_reset();
        test_load();
        test_blank();
        test_double_load();
        test_wrap_load();
        test_decode();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
